// File: rtl/apb_req_arbiter_if.sv
// Request/response and APB-master-side signals of one APB segment arbiter.
// slave: the arbiter itself; master: requesters plus the APB master environment.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_rdata;
  logic                  busy;
  logic [ID_W-1:0]       grant_id;
  logic                  TRANSFER;
  logic [31:0]           address;
  logic [31:0]           write_data;
  logic                  write_en;
  logic                  apb_psel;
  logic                  apb_pready;
  logic [31:0]           master_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  apb_psel, apb_pready, master_rdata,
    output req_ready, resp_valid, resp_rdata, busy, grant_id,
    output TRANSFER, address, write_data, write_en
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output apb_psel, apb_pready, master_rdata,
    input  req_ready, resp_valid, resp_rdata, busy, grant_id,
    input  TRANSFER, address, write_data, write_en
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Shares one APB master between NUM_REQ requesters: round-robin arbitration,
// command latch, TRANSFER sequencing and read-data return. APB_ARB_FIXED_PRIO_EN selects fixed priority.
module apb_req_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_req_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] grant_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            write_q;
  logic [31:0]     rdata_q;
  logic            any_req;
  logic            accept;
  logic            done;

  assign any_req = |bus.req_valid;
  // No handshake while reset is held, so a request is never accepted and then lost.
  assign accept  = PRESETn && (state_q == IDLE) && any_req;
  assign done    = bus.apb_psel && bus.apb_pready;

`ifdef APB_ARB_FIXED_PRIO_EN
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] v);
    logic [ID_W-1:0] w;
    w = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) w = ID_W'(i);
    end
    return w;
  endfunction

  always_comb winner = pick(bus.req_valid);
`else
  logic [ID_W-1:0] ptr_q;

  // Search starts one past the last winner so every port gets a turn.
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] v,
                                           input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] w;
    logic            found;
    int              idx;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && v[idx]) begin
        w     = ID_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb winner = pick(bus.req_valid, ptr_q);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      ptr_q <= winner;
    end
  end
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= winner;
        addr_q  <= bus.req_addr[32*winner +: 32];
        wdata_q <= bus.req_wdata[32*winner +: 32];
        write_q <= bus.req_write[winner];
      end
      if (state_q == RESP) begin
        rdata_q <= write_q ? 32'h0 : bus.master_rdata;
      end
    end
  end

  // resp_rdata shows live master data during RESP and the held copy afterwards.
  always_comb begin
    state_d        = state_q;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.resp_rdata = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          bus.req_ready[winner] = 1'b1;
          state_d               = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done) state_d = RESP;
      end
      RESP: begin
        bus.resp_valid[grant_q] = 1'b1;
        bus.resp_rdata          = write_q ? 32'h0 : bus.master_rdata;
        state_d                 = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.TRANSFER   = (state_q == ISSUE);
  assign bus.grant_id   = grant_q;
  assign bus.address    = addr_q;
  assign bus.write_data = wdata_q;
  assign bus.write_en   = write_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: a small APB master/slave model behind the arbiter and
// directed scenarios with hand-computed cycle numbers and data.
module tb_apb_req_arbiter;
  localparam int NUM_REQ = 4;

  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  apb_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();
  apb_req_arbiter #(.NUM_REQ(NUM_REQ)) dut (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // APB master + slave model: SETUP the cycle after TRANSFER, then ACCESS with slv_waits wait states.
  typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ACCESS} mst_t;
  mst_t        m_st;
  int unsigned wcnt;
  int unsigned slv_waits = 0;
  logic [31:0] slv_rdata = '0;
  logic [31:0] m_rdata;
  logic        pready;

  assign pready           = (m_st == M_ACCESS) && (wcnt >= slv_waits);
  assign bus.apb_psel     = (m_st != M_IDLE);
  assign bus.apb_pready   = pready;
  assign bus.master_rdata = m_rdata;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_st    <= M_IDLE;
      wcnt    <= 0;
      m_rdata <= '0;
    end else begin
      case (m_st)
        M_IDLE:  if (bus.TRANSFER) m_st <= M_SETUP;
        M_SETUP: begin m_st <= M_ACCESS; wcnt <= 0; end
        M_ACCESS: begin
          if (pready) begin
            if (!bus.write_en) m_rdata <= slv_rdata;
            m_st <= bus.TRANSFER ? M_SETUP : M_IDLE;
          end else begin
            wcnt <= wcnt + 1;
          end
        end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // Event log sampled on the falling edge.
  int          cyc = 0;
  int          acc_id[$], acc_cyc[$], rsp_id[$], rsp_cyc[$];
  logic [31:0] rsp_data[$];
  int          n_xfer = 0;
  int          n_acc  = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic        cap_write = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_ready[i]) begin
        acc_id.push_back(i); acc_cyc.push_back(cyc); n_acc++;
      end
      if (bus.resp_valid[i]) begin
        rsp_id.push_back(i); rsp_cyc.push_back(cyc); rsp_data.push_back(bus.resp_rdata);
      end
    end
    if (bus.TRANSFER) n_xfer++;
    if (bus.apb_psel && bus.apb_pready) begin
      cap_addr = bus.address; cap_wdata = bus.write_data; cap_write = bus.write_en;
    end
  end

  a_single_transfer: assert property (@(posedge PCLK) disable iff (!PRESETn)
    bus.TRANSFER |=> !bus.TRANSFER);
  a_transfer_after_accept: assert property (@(posedge PCLK) disable iff (!PRESETn)
    bus.TRANSFER |-> $past(|bus.req_ready));

  task automatic tick(); @(posedge PCLK); #1; endtask
  task automatic smp();  @(negedge PCLK); #1; endtask

  task automatic clear_log();
    acc_id.delete(); acc_cyc.delete(); rsp_id.delete(); rsp_cyc.delete(); rsp_data.delete();
  endtask

  task automatic wait_resp(input int n);
    for (int k = 0; k < 40 && rsp_id.size() < n; k++) smp();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && bus.busy; k++) smp();
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    smp();
    n_tests++;
    if ({bus.busy, bus.TRANSFER, bus.write_en, bus.resp_valid, bus.req_ready, bus.grant_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got busy=%0b xfer=%0b we=%0b rv=%b rr=%b gid=%0d exp all 0",
               bus.busy, bus.TRANSFER, bus.write_en, bus.resp_valid, bus.req_ready, bus.grant_id);
    end
    n_tests++;
    if (bus.address !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus.address); end
    n_tests++;
    if (bus.write_data !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", bus.write_data); end
    n_tests++;
    if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.resp_rdata); end
  endtask

  task automatic test_single_read();
    int c0;
    clear_log();
    slv_waits = 0; slv_rdata = 32'hA5A5A5A5;
    tick();
    bus.req_addr[0 +: 32] = 32'h10; bus.req_write[0] = 1'b0; bus.req_valid = 4'b0001;
    smp(); c0 = cyc;
    n_tests++;
    if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rd_ready got=%b exp=0001", bus.req_ready); end
    tick(); bus.req_valid = '0;
    smp();
    n_tests++;
    if (bus.TRANSFER !== 1'b1) begin n_fail++; $display("FAIL rd_transfer_c1 got=%0b exp=1", bus.TRANSFER); end
    wait_resp(1);
    n_tests++;
    if (rsp_id.size() == 0) begin
      n_fail++; $display("FAIL rd_resp_timeout got=none exp=resp_valid");
    end else begin
      n_tests += 2;
      if (rsp_cyc[0] - c0 != 4 || rsp_id[0] != 0) begin
        n_fail++; $display("FAIL rd_latency got=cyc%0d port%0d exp=cyc4 port0", rsp_cyc[0] - c0, rsp_id[0]);
      end
      if (rsp_data[0] !== 32'hA5A5A5A5) begin
        n_fail++; $display("FAIL rd_data got=%h exp=a5a5a5a5", rsp_data[0]);
      end
    end
    smp();
    n_tests++;
    if (bus.resp_valid !== '0 || bus.resp_rdata !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL rd_hold got=rv%b data=%h exp=rv0000 data=a5a5a5a5", bus.resp_valid, bus.resp_rdata);
    end
  endtask

  task automatic test_write_wait();
    int c0;
    clear_log();
    slv_waits = 3;
    tick();
    bus.req_addr[64 +: 32] = 32'h20; bus.req_wdata[64 +: 32] = 32'h12345678;
    bus.req_write[2] = 1'b1; bus.req_valid = 4'b0100;
    smp(); c0 = cyc;
    n_tests++;
    if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL wr_ready got=%b exp=0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    bus.req_addr[64 +: 32] = 32'hDEADBEEF; bus.req_wdata[64 +: 32] = 32'h0; bus.req_write[2] = 1'b0;
    wait_resp(1);
    n_tests++;
    if (rsp_id.size() == 0) begin
      n_fail++; $display("FAIL wr_resp_timeout got=none exp=resp_valid");
    end else begin
      n_tests += 2;
      if (rsp_cyc[0] - c0 != 7 || rsp_id[0] != 2) begin
        n_fail++; $display("FAIL wr_latency got=cyc%0d port%0d exp=cyc7 port2", rsp_cyc[0] - c0, rsp_id[0]);
      end
      if (rsp_data[0] !== 32'h0) begin n_fail++; $display("FAIL wr_rdata got=%h exp=0", rsp_data[0]); end
    end
    n_tests++;
    if (cap_addr !== 32'h20 || cap_wdata !== 32'h12345678 || cap_write !== 1'b1) begin
      n_fail++; $display("FAIL wr_bus got=%h/%h/%0b exp=00000020/12345678/1", cap_addr, cap_wdata, cap_write);
    end
    n_tests++;
    if (bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL wr_grant got=%0d exp=2", bus.grant_id); end
    slv_waits = 0;
    wait_idle();
  endtask

  task automatic test_round_robin();
    int exp_id;
    PRESETn = 1'b0;
    tick(); tick();
    PRESETn = 1'b1;
    clear_log();
    for (int p = 0; p < NUM_REQ; p++) bus.req_addr[32*p +: 32] = 32'h100 + 32'(p);
    bus.req_write = '0;
    tick();
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 40 && acc_id.size() < 5; k++) smp();
    tick();
    bus.req_valid = '0;
    wait_idle();
    n_tests++;
    if (acc_id.size() != 5) begin
      n_fail++; $display("FAIL rr_count got=%0d exp=5", acc_id.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
`ifdef APB_ARB_FIXED_PRIO_EN
        exp_id = 0;
`else
        exp_id = k % NUM_REQ;
`endif
        n_tests++;
        if (acc_id[k] != exp_id) begin
          n_fail++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, acc_id[k], exp_id);
        end
        if (k > 0) begin
          n_tests++;
          if (acc_cyc[k] - acc_cyc[k-1] != 5) begin
            n_fail++; $display("FAIL rr_spacing[%0d] got=%0d exp=5", k, acc_cyc[k] - acc_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_busy_queue();
    clear_log();
    slv_waits = 0; slv_rdata = 32'h33333333;
    tick();
    bus.req_addr[96 +: 32] = 32'h40; bus.req_valid = 4'b1000;
    smp();
    n_tests++;
    if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL q_ready3 got=%b exp=1000", bus.req_ready); end
    tick(); bus.req_valid = 4'b0010;
    smp();
    n_tests++;
    if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL q_ready_busy got=%b exp=0000", bus.req_ready); end
    tick(); bus.req_valid = 4'b0011;
    tick(); bus.req_valid = 4'b0010;
    for (int k = 0; k < 40 && acc_id.size() < 2; k++) smp();
    tick(); bus.req_valid = '0;
    wait_resp(2);
    wait_idle();
    n_tests++;
    if (acc_id.size() != 2 || rsp_id.size() != 2) begin
      n_fail++; $display("FAIL q_counts got=acc%0d rsp%0d exp=acc2 rsp2", acc_id.size(), rsp_id.size());
    end else begin
      n_tests += 3;
      if (acc_id[0] != 3 || acc_id[1] != 1) begin
        n_fail++; $display("FAIL q_order got=%0d,%0d exp=3,1", acc_id[0], acc_id[1]);
      end
      if (rsp_id[0] != 3 || acc_cyc[1] != rsp_cyc[0] + 1) begin
        n_fail++; $display("FAIL q_timing got=rsp_port%0d gap%0d exp=rsp_port3 gap1", rsp_id[0], acc_cyc[1] - rsp_cyc[0]);
      end
      if (rsp_id[1] != 1 || rsp_data[1] !== 32'h33333333) begin
        n_fail++; $display("FAIL q_second got=port%0d data=%h exp=port1 data=33333333", rsp_id[1], rsp_data[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c0, r0;
    clear_log();
    slv_waits = 5; slv_rdata = 32'h77777777;
    tick();
    bus.req_addr[64 +: 32] = 32'h50; bus.req_write[2] = 1'b0; bus.req_valid = 4'b0100;
    tick(); bus.req_valid = '0;
    tick(); tick();
    smp();
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_before got=%0b exp=1", bus.busy); end
    r0 = rsp_id.size();
    PRESETn = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.TRANSFER !== 1'b0 || bus.resp_valid !== '0) begin
      n_fail++; $display("FAIL rm_ctrl got=busy%0b xfer%0b rv%b exp=0/0/0000", bus.busy, bus.TRANSFER, bus.resp_valid);
    end
    n_tests++;
    if (bus.grant_id !== 2'd0 || bus.address !== 32'h0) begin
      n_fail++; $display("FAIL rm_regs got=gid%0d addr=%h exp=gid0 addr=0", bus.grant_id, bus.address);
    end
    tick(); tick();
    PRESETn = 1'b1;
    slv_waits = 0;
    repeat (6) smp();
    n_tests++;
    if (rsp_id.size() != r0) begin n_fail++; $display("FAIL rm_no_resp got=%0d exp=%0d", rsp_id.size(), r0); end
    clear_log();
    slv_rdata = 32'h5A5A5A5A;
    tick();
    bus.req_addr[0 +: 32] = 32'h60; bus.req_write[0] = 1'b0; bus.req_valid = 4'b0001;
    smp(); c0 = cyc;
    n_tests++;
    if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_ready got=%b exp=0001", bus.req_ready); end
    tick(); bus.req_valid = '0;
    wait_resp(1);
    n_tests++;
    if (rsp_id.size() == 0) begin
      n_fail++; $display("FAIL rm_resp_timeout got=none exp=resp_valid");
    end else if (rsp_cyc[0] - c0 != 4 || rsp_id[0] != 0 || rsp_data[0] !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL rm_after got=cyc%0d port%0d data=%h exp=cyc4 port0 data=5a5a5a5a",
                         rsp_cyc[0] - c0, rsp_id[0], rsp_data[0]);
    end
    wait_idle();
  endtask

  task automatic test_transfer_count();
    n_tests++;
    if (n_xfer != n_acc || n_acc != 11) begin
      n_fail++; $display("FAIL xfer_count got=xfer%0d acc%0d exp=11/11", n_xfer, n_acc);
    end
  endtask

  initial begin
    PRESETn       = 1'b1;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_single_read();
    test_write_wait();
    test_round_robin();
    test_busy_queue();
    test_reset_mid();
    test_transfer_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
